// File: rtl/gate_test_sequencer.sv
// Steps a 2-input gate through all four input vectors and checks its output against a truth table.
// Latency: done pulses 4*(HOLD_CYCLES+1) cycles after start; a run is cancelled by abort or reset.
module gate_test_sequencer #(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter logic [3:0]  EXPECT_TT   = 4'b1000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       abort,
    output logic       a,
    output logic       b,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [2:0] err_count,
    output logic [3:0] fail_vec
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, DONE} state_t;

    localparam logic [7:0] HOLD_LAST = 8'(HOLD_CYCLES - 1);

    state_t     state, state_n;
    logic [1:0] idx, idx_n;
    logic [7:0] hold_cnt, hold_cnt_n;
    logic       a_n, b_n, busy_n, done_n, pass_n;
    logic [2:0] err_n;
    logic [3:0] fail_n;

    always_comb begin
        state_n    = state;
        idx_n      = idx;
        hold_cnt_n = hold_cnt;
        a_n        = a;
        b_n        = b;
        busy_n     = busy;
        done_n     = 1'b0;
        pass_n     = pass;
        err_n      = err_count;
        fail_n     = fail_vec;

        case (state)
            IDLE: begin
                if (start) begin
                    state_n    = DRIVE;
                    idx_n      = 2'd0;
                    hold_cnt_n = 8'd0;
                    a_n        = 1'b0;
                    b_n        = 1'b0;
                    busy_n     = 1'b1;
                    pass_n     = 1'b0;
                    err_n      = 3'd0;
                    fail_n     = 4'd0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_n = IDLE;
                    a_n     = 1'b0;
                    b_n     = 1'b0;
                    busy_n  = 1'b0;
                    pass_n  = 1'b0;
                end else if (hold_cnt == HOLD_LAST) begin
                    state_n = SAMPLE;
                end else begin
                    hold_cnt_n = hold_cnt + 8'd1;
                end
            end
            SAMPLE: begin
                // abort wins: the vector being sampled is not scored
                if (abort) begin
                    state_n = IDLE;
                    a_n     = 1'b0;
                    b_n     = 1'b0;
                    busy_n  = 1'b0;
                    pass_n  = 1'b0;
                end else begin
                    if (y != EXPECT_TT[idx]) begin
                        fail_n[idx] = 1'b1;
                        if (err_count < 3'd4)
                            err_n = err_count + 3'd1;
                    end
                    if (idx == 2'd3) begin
                        state_n = DONE;
                        a_n     = 1'b0;
                        b_n     = 1'b0;
                        busy_n  = 1'b0;
                        done_n  = 1'b1;
                        pass_n  = (err_n == 3'd0);
                    end else begin
                        state_n    = DRIVE;
                        idx_n      = idx + 2'd1;
                        hold_cnt_n = 8'd0;
                        {a_n, b_n} = idx + 2'd1;
                    end
                end
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= 2'd0;
            hold_cnt  <= 8'd0;
            a         <= 1'b0;
            b         <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 3'd0;
            fail_vec  <= 4'd0;
        end else begin
            state     <= state_n;
            idx       <= idx_n;
            hold_cnt  <= hold_cnt_n;
            a         <= a_n;
            b         <= b_n;
            busy      <= busy_n;
            done      <= done_n;
            pass      <= pass_n;
            err_count <= err_n;
            fail_vec  <= fail_n;
        end
    end

endmodule
